// File: rtl/mux_t_t_t_n_if.sv
// mux_t_t_t_n_if: temporal input/select lines and match results of mux_t_t_t_n
interface mux_t_t_t_n_if #(
  parameter int NUM_INPUTS = 16,
  parameter int GAMMA_CYCLE_WIDTH = 16
);
  localparam int TW = $clog2(GAMMA_CYCLE_WIDTH);
  localparam int IW = $clog2(NUM_INPUTS);
  logic [NUM_INPUTS-1:0] inputs;
  logic select_line;
  logic y;
  logic fired;
  logic [IW-1:0] match_idx;
  logic [TW-1:0] sel_time;
  logic miss;
  modport master (output inputs, select_line, input y, fired, match_idx, sel_time, miss);
  modport slave (input inputs, select_line, output y, fired, match_idx, sel_time, miss);
endinterface

// File: rtl/mux_t_t_t_n.sv
// mux_t_t_t_n: clocked temporal mux firing once per gamma cycle when an input lands within TOL ticks of the select
module mux_t_t_t_n #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH = 8,
  parameter int NUM_INPUTS = GAMMA_CYCLE_WIDTH,
  parameter int MODE = 0,
  parameter int TOL = 0
) (
  input logic clk,
  input logic rst_n,
  input logic grst,
  mux_t_t_t_n_if.slave bus
);
  localparam int TW = $clog2(GAMMA_CYCLE_WIDTH);
  localparam int TWP = TW + 1;
  localparam int IW = $clog2(NUM_INPUTS);
  localparam int PCW = $clog2(PULSE_WIDTH + 1);
  localparam logic [TW-1:0] T_MAX = TW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [TW:0] TOL_W = TWP'(TOL);
  localparam logic IDLE_LVL = (MODE == 1);
  typedef enum logic [1:0] {IDLE, WAIT, FIRE, DONE} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [NUM_INPUTS-1:0] in_prev_q, in_prev_d;
  logic sel_prev_q, sel_prev_d;
  logic [NUM_INPUTS-1:0] in_seen_q, in_seen_d;
  logic [NUM_INPUTS-1:0][TW-1:0] in_time_q, in_time_d;
  logic sel_seen_q, sel_seen_d;
  logic [TW-1:0] sel_time_q, sel_time_d;
  logic y_q, y_d;
  logic fired_q, fired_d;
  logic [IW-1:0] idx_q, idx_d;
  logic miss_q, miss_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic t_live;
  logic [NUM_INPUTS-1:0] in_ev;
  logic sel_ev;
  logic [TW:0] diff, adiff;
  logic [NUM_INPUTS-1:0] match;
  logic [IW-1:0] win_idx;
  logic any_match;
  logic fire;
  // Edge detection in the active encoding; events at saturated t or during grst count as never
  always_comb begin
    t_live = (t_q != T_MAX) && !grst;
    in_ev = (MODE == 1 ? (~bus.inputs & in_prev_q) : (bus.inputs & ~in_prev_q)) & {NUM_INPUTS{t_live}};
    sel_ev = (MODE == 1 ? (~bus.select_line & sel_prev_q) : (bus.select_line & ~sel_prev_q)) & t_live;
  end
  // Window compare of every captured input against the captured select; lowest index wins
  always_comb begin
    diff = '0;
    adiff = '0;
    match = '0;
    win_idx = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      diff = {1'b0, in_time_q[i]} - {1'b0, sel_time_q};
      adiff = diff[TW] ? (~diff + 1'b1) : diff;
      match[i] = sel_seen_q & in_seen_q[i] & (adiff <= TOL_W);
    end
    for (int i = NUM_INPUTS - 1; i >= 0; i--)
      if (match[i]) win_idx = IW'(i);
    any_match = |match;
  end
  // Next state: capture, FSM, fire effects and output shaping; grst overrides everything
  always_comb begin
    state_d = state_q;
    fire = 1'b0;
    in_prev_d = bus.inputs;
    sel_prev_d = bus.select_line;
    t_d = (t_q == T_MAX) ? t_q : t_q + 1'b1;
    in_seen_d = in_seen_q | in_ev;
    in_time_d = in_time_q;
    for (int i = 0; i < NUM_INPUTS; i++)
      if (in_ev[i] && !in_seen_q[i]) in_time_d[i] = t_q;
    sel_seen_d = sel_seen_q | sel_ev;
    sel_time_d = (sel_ev && !sel_seen_q) ? t_q : sel_time_q;
    miss_d = 1'b0;
    case (state_q)
      IDLE: state_d = sel_ev ? WAIT : IDLE;
      WAIT: begin
        fire = any_match;
        state_d = any_match ? FIRE : WAIT;
      end
      FIRE: state_d = DONE;
      default: state_d = state_q;
    endcase
    fired_d = fired_q | fire;
    idx_d = fire ? win_idx : idx_q;
    pcnt_d = '0;
    y_d = fire ? ~IDLE_LVL : y_q;
    if (MODE == 2) begin
      pcnt_d = fire ? PCW'(PULSE_WIDTH - 1) : ((pcnt_q != '0) ? pcnt_q - 1'b1 : pcnt_q);
      y_d = fire | (y_q & (pcnt_q != '0));
    end
    if (grst) begin
      state_d = IDLE;
      t_d = '0;
      in_seen_d = '0;
      in_time_d = '0;
      sel_seen_d = 1'b0;
      sel_time_d = '0;
      fired_d = 1'b0;
      idx_d = '0;
      y_d = IDLE_LVL;
      pcnt_d = '0;
      miss_d = (state_q == WAIT);
    end
  end
  // State registers, asynchronously cleared to the encoding's idle levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q <= '0;
      in_prev_q <= {NUM_INPUTS{IDLE_LVL}};
      sel_prev_q <= IDLE_LVL;
      in_seen_q <= '0;
      in_time_q <= '0;
      sel_seen_q <= 1'b0;
      sel_time_q <= '0;
      y_q <= IDLE_LVL;
      fired_q <= 1'b0;
      idx_q <= '0;
      miss_q <= 1'b0;
      pcnt_q <= '0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      in_prev_q <= in_prev_d;
      sel_prev_q <= sel_prev_d;
      in_seen_q <= in_seen_d;
      in_time_q <= in_time_d;
      sel_seen_q <= sel_seen_d;
      sel_time_q <= sel_time_d;
      y_q <= y_d;
      fired_q <= fired_d;
      idx_q <= idx_d;
      miss_q <= miss_d;
      pcnt_q <= pcnt_d;
    end
  end
  assign bus.y = y_q;
  assign bus.fired = fired_q;
  assign bus.match_idx = idx_q;
  assign bus.sel_time = sel_time_q;
  assign bus.miss = miss_q;
endmodule

// File: doc/mux_t_t_t_n.md
Name: mux_t_t_t_n

Overview:
- Clocked, parametrised successor of the unclocked temporal race-logic mux.
- Takes NUM_INPUTS edge-encoded temporal inputs and one temporal select line.
- Within each gamma cycle, fires a single output event when some input's arrival time lies within TOL ticks of the select's arrival time. It reports which channel matched.
- Sits between column/neuron outputs and downstream temporal logic. One instance supports rising-edge, falling-edge or pulse encoding via MODE.

Parameters:
- GAMMA_CYCLE_WIDTH, 16: ticks per gamma cycle. Time stamp width TW = $clog2(GAMMA_CYCLE_WIDTH).
- PULSE_WIDTH, 8: output pulse length in clk cycles (MODE=2 only). Must be >= 1.
- NUM_INPUTS, GAMMA_CYCLE_WIDTH: number of temporal input channels. Must be >= 2. IW = $clog2(NUM_INPUTS).
- MODE, 0: 0 = rising-edge encoding, 1 = falling-edge encoding, 2 = pulse encoding.
- TOL, 0: match window in ticks, inclusive. Must be < GAMMA_CYCLE_WIDTH.

Ports:
- clk  input  1  system clock; all inputs synchronous to it.
- rst_n  input  1  asynchronous active-low reset.
- grst  input  1  gamma-cycle reset, one-cycle synchronous pulse.
- inputs  input  NUM_INPUTS  temporal input channels.
- select_line  input  1  temporal select.
- y  output  1  temporal result.
- fired  output  1  high from fire until next grst.
- match_idx  output  IW  channel that matched; valid while fired=1.
- sel_time  output  TW  captured select arrival tick.
- miss  output  1  one-cycle pulse on grst if select arrived but nothing fired.

Behaviour:
- Reset (rst_n=0, async), all registers cleared:
  - y=1 if MODE=1, else y=0.
  - fired=0, match_idx=0, sel_time=0, miss=0.
  - State IDLE; tick counter t=0.
  - Edge history registers: all 0 for MODE 0/2, all 1 for MODE 1.
- Tick counter t:
  - Cleared to 0 in the cycle after grst.
  - Otherwise increments by 1 per clk.
  - Saturates at GAMMA_CYCLE_WIDTH-1 (no wrap).
  - Events seen while t is saturated are ignored (treated as "never", infinite time).
- Event detection per line, using a registered previous value:
  - MODE 0/2: event = cur & ~prev.
  - MODE 1: event = ~cur & prev.
  - Only the first event per line per gamma cycle is captured: seen flag plus TW-bit time stamp = t in the event cycle.
  - Later events on a captured line are ignored.
- Match rule:
  - Channel i matches when both sel_seen and seen_i are set and |time_i - sel_time| <= TOL.
  - Subtraction is unsigned on TW+1 bits, absolute value taken.
  - If several channels match in the same evaluation cycle, the lowest index wins.
- State machine:
  - IDLE → WAIT on select capture.
  - WAIT → FIRE on the first cycle any match exists. This covers both orders:
    - input earlier by <= TOL: matches when select is captured;
    - input later: matches when the input is captured.
  - FIRE → DONE after one cycle.
  - DONE holds until grst.
  - Input events captured in IDLE are still time-stamped, so they remain eligible once select arrives.
- Latency and fire effects:
  - y changes at the start of the 2nd cycle after the cycle in which the later of the matching pair appeared on the pins. That is, event in cycle c: capture at end of c, compare in c+1, y registered at end of c+1.
  - fired and match_idx update in the same cycle as y.
- Output y by MODE:
  - MODE 0: y rises at fire and stays 1 until grst.
  - MODE 1: y set to 1 by grst, falls at fire, stays 0 until next grst.
  - MODE 2: y is 1 for exactly PULSE_WIDTH cycles from fire, driven by a down-counter, then 0.
- At most one fire per gamma cycle.
- grst, synchronous, priority over everything:
  - Clears t, seen flags, time stamps, state, fired and match_idx.
  - y returns to the MODE reset value; this truncates an active MODE 2 pulse.
  - Events present in the grst cycle are ignored, but prev registers still update.
  - miss=1 in the cycle after grst iff the state was WAIT when grst arrived.
- rst_n asserted mid-cycle: immediate return to reset values; no partial pulse continues.

Test Plan:
- MODE 0, TOL 0, N=16: grst; select event at tick 5, inputs[3] event at tick 5 → y=1 at cycle 7 after grst release, match_idx=3, fired=1, y holds until next grst.
- MODE 0, TOL 2: inputs[7] at tick 4, select at tick 6 → fire 2 cycles after select arrival, match_idx=7. Repeat with input at tick 9 → no fire; next grst gives miss=1.
- Tie: inputs[2] and inputs[9] both at tick 3, select at tick 3 → match_idx=2, single fire. Later inputs[5] at tick 3 again has no effect.
- MODE 1: falling edges on select and inputs[0] at tick 10 → y drops from 1 to 0 two cycles later. grst → y=1, fired=0.
- MODE 2, PULSE_WIDTH 8: match at tick 2 → y high exactly 8 cycles. Repeat with grst issued 3 cycles into the pulse → y=0 the cycle after grst.
- Saturation/reset: no grst for 20 cycles with GAMMA_CYCLE_WIDTH=16, events at cycle 18 → ignored, no fire. Assert rst_n=0 during a MODE 2 pulse → y=0 immediately; all outputs at reset values.
